// File: rtl/reg_file_pkg.sv
// Shared constants and types for reg_file and its sweep reader.
package reg_file_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} rfr_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;
endpackage

// File: rtl/reg_file.sv
// Register file with one synchronous write port and one combinational read port.
module reg_file #(
  parameter int DATA_W   = reg_file_pkg::DATA_W,
  parameter int ADDR_W   = reg_file_pkg::ADDR_W,
  parameter int NUM_REGS = reg_file_pkg::NUM_REGS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else if (we && (32'(waddr) < NUM_REGS)) begin
      mem[waddr] <= wdata;
    end
  end

  // Out-of-range addresses read as zero.
  assign rdata = (32'(raddr) < NUM_REGS) ? mem[raddr] : '0;
endmodule

// File: rtl/reg_file_reader.sv
// Sweeps reg_file entries first_addr..last_addr through the read port and
// streams each as an {addr, data, last} beat over valid/ready.
//
// state | meaning
// IDLE  | waiting for start; bad ranges pulse err/done here
// SWEEP | loading one entry per accepted slot into the output register
// DRAIN | final beat loaded, waiting for it to be accepted
module reg_file_reader #(
  parameter int DATA_W   = reg_file_pkg::DATA_W,
  parameter int ADDR_W   = reg_file_pkg::ADDR_W,
  parameter int NUM_REGS = reg_file_pkg::NUM_REGS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              err
);
  import reg_file_pkg::*;

  rfr_state_t        state, state_nxt;
  logic [ADDR_W-1:0] ptr, end_addr;
  logic              range_ok, accept, reject, finish, load, at_end;

  assign range_ok = (first_addr <= last_addr) && (32'(last_addr) < NUM_REGS);
  assign load     = (state == SWEEP) && (!out_valid || out_ready);
  assign at_end   = (ptr == end_addr);
  assign raddr    = ptr;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    reject    = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (range_ok) begin
            accept    = 1'b1;
            state_nxt = SWEEP;
          end else begin
            reject    = 1'b1;
          end
        end
      end
      SWEEP: begin
        if (abort) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end else if (load && at_end) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (abort || (out_valid && out_ready)) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      end_addr  <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= finish || reject;
      err  <= reject;
      if (accept) begin
        ptr      <= first_addr;
        end_addr <= last_addr;
      end
      // Abort takes priority over any load or handshake in the same cycle.
      if (abort && (state != IDLE)) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end else if (load) begin
        out_data  <= rdata;
        out_addr  <= ptr;
        out_valid <= 1'b1;
        out_last  <= at_end;
        if (!at_end) ptr <= ptr + ADDR_W'(1);
      end else if ((state == DRAIN) && out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end
endmodule
